// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES memory arbiter: requester indices and default widths.
package nes_mem_pkg;

  localparam int NUM_REQ    = 3;
  localparam int DEF_ADDR_W = 15;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    REQ_PPU = 2'd0,
    REQ_CPU = 2'd1,
    REQ_HPS = 2'd2
  } req_idx_e;

  // Map a one-hot (or zero) grant vector to the requester index it selects.
  function automatic req_idx_e onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    req_idx_e idx;
    idx = REQ_PPU;
    if (oh[REQ_HPS]) idx = REQ_HPS;
    else if (oh[REQ_CPU]) idx = REQ_CPU;
    return idx;
  endfunction

endpackage

// File: rtl/nes_mem_arbiter_if.sv
// Requester-side and RAM-side bus of the NES memory arbiter.
// master = requesters, slave = arbiter, ram = RAM macro.
interface nes_mem_arbiter_if
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_i;
  logic [NUM_REQ-1:0]             we_i;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]             gnt;
  logic [NUM_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]              rdata;
  logic [ADDR_W-1:0]              mem_addr;
  logic                           mem_we;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;

  modport master (
    output req, addr_i, we_i, wdata_i,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr_i, we_i, wdata_i, mem_rdata,
    output gnt, rvalid, rdata, mem_addr, mem_we, mem_wdata
  );

  modport ram (
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/nes_rr_pick2.sv
// Combinational two-way round-robin pick: ptr names the side that goes first.
module nes_rr_pick2 (
  input  logic [1:0] eligible,
  input  logic       ptr,
  output logic [1:0] onehot
);

  // Favoured side wins if eligible, otherwise the other side.
  always_comb begin
    onehot = 2'b00;
    if (!ptr) begin
      if (eligible[0])      onehot = 2'b01;
      else if (eligible[1]) onehot = 2'b10;
    end else begin
      if (eligible[1])      onehot = 2'b10;
      else if (eligible[0]) onehot = 2'b01;
    end
  end

endmodule

// File: rtl/nes_mem_arbiter.sv
// Single-port RAM arbiter for PPU (strict priority), CPU and HPS (round-robin).
// Optional feature macro: MEM_ARB_AGE_EN -- per-CPU/HPS wait counters; a request
// that has waited AGE_LIMIT cycles outranks the PPU.
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int AGE_LIMIT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  nes_mem_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] win;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic               mem_we_q, mem_we_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [1:0]         rr_pick;
  logic [NUM_REQ-1:0] rvalid_o;
  req_idx_e           win_idx;

  // A requester granted last cycle sits out this one.
  assign eligible = bus.req & ~gnt_q;

  nes_rr_pick2 u_rr_pick (
    .eligible (eligible[2:1]),
    .ptr      (rr_ptr_q),
    .onehot   (rr_pick)
  );

`ifdef MEM_ARB_AGE_EN
  localparam logic [3:0] AGE_LIM = 4'(AGE_LIMIT);

  logic [1:0][3:0] age_q, age_d;
  logic [1:0]      aged;
  logic [1:0]      aged_pick;

  // Flag CPU/HPS requests that have waited long enough to pre-empt the PPU.
  always_comb begin
    aged = 2'b00;
    for (int k = 0; k < 2; k++) begin
      aged[k] = eligible[k+1] && (age_q[k] >= AGE_LIM);
    end
  end

  nes_rr_pick2 u_age_pick (
    .eligible (aged),
    .ptr      (rr_ptr_q),
    .onehot   (aged_pick)
  );

  // Aged CPU/HPS first, then the PPU, then CPU/HPS in round-robin order.
  always_comb begin
    win = '0;
    if (|aged)             win = {aged_pick, 1'b0};
    else if (eligible[0])  win = 3'b001;
    else                   win = {rr_pick, 1'b0};
  end

  // Saturating wait counters: count ungranted request cycles, clear otherwise.
  always_comb begin
    age_d = age_q;
    for (int k = 0; k < 2; k++) begin
      if (bus.req[k+1] && !win[k+1])
        age_d[k] = (age_q[k] == 4'hF) ? 4'hF : age_q[k] + 4'd1;
      else
        age_d[k] = 4'd0;
    end
  end

  // Wait counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) age_q <= '0;
    else          age_q <= age_d;
  end
`else
  // AGE_LIMIT has no effect without the age path.
  logic unused_age_limit;
  assign unused_age_limit = ^32'(AGE_LIMIT);

  // PPU first, then CPU/HPS in round-robin order.
  always_comb begin
    win = '0;
    if (eligible[0]) win = 3'b001;
    else             win = {rr_pick, 1'b0};
  end
`endif

  // Register the winner's access; rvalid follows a read grant by one cycle.
  always_comb begin
    gnt_d       = win;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    rvalid_d    = gnt_q & {NUM_REQ{~mem_we_q}};
    win_idx     = onehot_to_idx(win);
    if (|win) begin
      mem_addr_d  = bus.addr_i[win_idx];
      mem_we_d    = bus.we_i[win_idx];
      mem_wdata_d = bus.wdata_i[win_idx];
    end
    if (win[REQ_CPU])      rr_ptr_d = 1'b1;
    else if (win[REQ_HPS]) rr_ptr_d = 1'b0;
  end

  // Grant, RAM command and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt_q       <= '0;
      rvalid_q    <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rr_ptr_q    <= 1'b0;
    end else begin
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // rvalid is masked by reset_n so an in-flight pulse vanishes as soon as reset asserts.
  assign rvalid_o      = rvalid_q & {NUM_REQ{reset_n}};
  assign bus.rvalid    = rvalid_o;
  assign bus.rdata     = (|rvalid_o) ? bus.mem_rdata : '0;
  assign bus.gnt       = gnt_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_nes_mem_arbiter.sv
// Directed bench for nes_mem_arbiter with a 1-cycle-latency RAM model.
module tb_nes_mem_arbiter;

`ifdef MEM_ARB_AGE_EN
  localparam int AGE_LIM = 3;
`else
  localparam int AGE_LIM = 15;
`endif

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_bad;

  nes_mem_arbiter_if #(.ADDR_W(15), .DATA_W(8)) bus ();

  nes_mem_arbiter #(.ADDR_W(15), .DATA_W(8), .AGE_LIMIT(AGE_LIM)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  logic [7:0] ram [0:32767];
  logic [7:0] ram_q;

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    ram_q <= ram[bus.mem_addr];
  end
  assign bus.mem_rdata = ram_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] data_for(input logic [2:0] g);
    logic [7:0] d;
    d = 8'h00;
    if (g == 3'b001) d = 8'h5A;
    else if (g == 3'b010) d = 8'hA5;
    else if (g == 3'b100) d = 8'h3C;
    return d;
  endfunction

  logic [2:0] seq [0:3];
  logic [2:0] prev_g;
  bit         found;

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_bad = 0;
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b001; seq[3] = 3'b100;
    ram[15'h2000] = 8'h5A;
    reset_n = 1'b0;
    bus.req = 3'b111;
    bus.we_i = 3'b000;
    bus.addr_i[0] = 15'h2000; bus.wdata_i[0] = 8'h00;
    bus.addr_i[1] = 15'h0010; bus.wdata_i[1] = 8'hA5;
    bus.addr_i[2] = 15'h0011; bus.wdata_i[2] = 8'h3C;

    // Reset held with all requesting
    repeat (3) tick();
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_rvalid", 32'(bus.rvalid), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
    reset_n = 1'b1;
    tick();
    chk("first_gnt_ppu", 32'(bus.gnt), 32'b001);
    bus.req = 3'b000;
    repeat (3) tick();

    // PPU read
    bus.req = 3'b001;
    tick();
    chk("ppu_gnt", 32'(bus.gnt), 32'b001);
    chk("ppu_mem_addr", 32'(bus.mem_addr), 32'h2000);
    chk("ppu_mem_we", 32'(bus.mem_we), 0);
    bus.req = 3'b000;
    tick();
    chk("ppu_rvalid", 32'(bus.rvalid), 32'b001);
    chk("ppu_rdata", 32'(bus.rdata), 32'h5A);
    chk("ppu_gnt_drop", 32'(bus.gnt), 0);
    tick();

    // Simultaneous CPU/HPS writes
    bus.we_i = 3'b110;
    bus.req = 3'b110;
    tick();
    chk("wr_cpu_gnt", 32'(bus.gnt), 32'b010);
    chk("wr_cpu_we", 32'(bus.mem_we), 1);
    chk("wr_cpu_addr", 32'(bus.mem_addr), 32'h0010);
    chk("wr_cpu_wdata", 32'(bus.mem_wdata), 32'hA5);
    bus.req = 3'b100;
    tick();
    chk("wr_hps_gnt", 32'(bus.gnt), 32'b100);
    chk("wr_hps_addr", 32'(bus.mem_addr), 32'h0011);
    chk("wr_hps_wdata", 32'(bus.mem_wdata), 32'h3C);
    chk("wr_no_rvalid0", 32'(bus.rvalid), 0);
    bus.req = 3'b000;
    tick();
    chk("wr_idle_gnt", 32'(bus.gnt), 0);
    chk("wr_idle_we", 32'(bus.mem_we), 0);
    chk("wr_idle_addr_hold", 32'(bus.mem_addr), 32'h0011);
    chk("wr_no_rvalid1", 32'(bus.rvalid), 0);
    tick();
    chk("ram_0010", 32'(ram[15'h0010]), 32'hA5);
    chk("ram_0011", 32'(ram[15'h0011]), 32'h3C);
    bus.we_i = 3'b000;
    tick();

    // All three reading continuously
    prev_g = 3'b000;
    bus.req = 3'b111;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("seq_gnt%0d", i), 32'(bus.gnt), 32'(seq[i % 4]));
      chk($sformatf("seq_rvalid%0d", i), 32'(bus.rvalid), 32'(prev_g));
      if (prev_g != 3'b000)
        chk($sformatf("seq_rdata%0d", i), 32'(bus.rdata), 32'(data_for(prev_g)));
      prev_g = seq[i % 4];
    end
    bus.req = 3'b000;
    tick();
    chk("seq_rvalid_last", 32'(bus.rvalid), 32'b100);
    chk("seq_rdata_last", 32'(bus.rdata), 32'h3C);
    tick();

    // Reset in the cycle after a CPU read grant
    bus.req = 3'b010;
    tick();
    chk("mid_cpu_gnt", 32'(bus.gnt), 32'b010);
    reset_n = 1'b0;
    bus.req = 3'b000;
    tick();
    chk("mid_rvalid0", 32'(bus.rvalid), 0);
    chk("mid_gnt", 32'(bus.gnt), 0);
    tick();
    chk("mid_rvalid1", 32'(bus.rvalid), 0);
    reset_n = 1'b1;
    bus.req = 3'b110;
    tick();
    chk("mid_rrptr_cpu_first", 32'(bus.gnt), 32'b010);
    bus.req = 3'b000;
    repeat (2) tick();

`ifdef MEM_ARB_AGE_EN
    // Aged HPS request under continuous PPU pressure
    found = 1'b0;
    bus.req = 3'b111;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (!found && bus.gnt[2]) found = 1'b1;
    end
    chk("age_hps_within4", 32'(found), 1);
    bus.req = 3'b000;
    repeat (2) tick();
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
